axis_pkt_fsm: RTL and testbench
===============================

AXIS_PKT_FSM -- requirements
Module: axis_pkt_fsm

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, meaning the data bus width in bits (legal range 8..64).
REQ-002 The block SHALL have parameter MAX_BEATS, default 16, meaning the maximum beats per forwarded packet (legal range 2..255).
REQ-003 The block SHALL have derived localparam CNT_W = $clog2(MAX_BEATS+1).
REQ-004 The block SHALL have port aclk, input, 1 bit, the single clock; all logic is rising-edge.
REQ-005 The block SHALL have port aresetn, input, 1 bit, reset; it is asynchronous and active-low.
REQ-006 The block SHALL have port data_in, input, DATA_W bits, the upstream beat data.
REQ-007 The block SHALL have port tvalid, input, 1 bit, the upstream valid.
REQ-008 The block SHALL have port tlast, input, 1 bit, the upstream end-of-packet.
REQ-009 The block SHALL have port tready, output, 1 bit, the upstream ready.
REQ-010 The block SHALL have port data_out, output, DATA_W bits, the downstream data.
REQ-011 The block SHALL have port tvalid_out, output, 1 bit, the downstream valid.
REQ-012 The block SHALL have port tlast_out, output, 1 bit, the downstream end-of-packet.
REQ-013 The block SHALL have port tready_in, input, 1 bit, the downstream ready.
REQ-014 The block SHALL have port trunc_err, output, 1 bit, a one-cycle pulse when a packet is truncated.
REQ-015 The block SHALL have port pkt_len, output, CNT_W bits, the beat count of the last forwarded packet.
REQ-016 The block SHALL have port pkt_done, output, 1 bit, a one-cycle pulse qualifying pkt_len.
REQ-017 The block SHALL have port pkt_count, output, 16 bits, the count of packets forwarded since reset.

Function
REQ-018 An upstream transfer SHALL occur when tvalid and tready are both high; a downstream transfer SHALL occur when tvalid_out and tready_in are both high.
REQ-019 The output path SHALL be a 2-entry skid buffer: tready is registered and high whenever fewer than 2 entries are held, giving full throughput and no combinational path from tready_in to tready.
REQ-020 Latency from upstream transfer to tvalid_out SHALL be 1 cycle when the buffer is empty; beat order SHALL be preserved.
REQ-021 tvalid_out, data_out and tlast_out SHALL hold stable while tvalid_out is high and tready_in is low.
REQ-022 The FSM SHALL have states IDLE, PAYLOAD and DROP, encoded in a package enum.
REQ-023 From IDLE, an accepted beat with tlast=1 SHALL be forwarded as a 1-beat packet with no state change; with tlast=0 the state SHALL move to PAYLOAD with beat count 1.
REQ-024 In PAYLOAD, each accepted beat SHALL increment the beat count; an accepted beat with tlast=1 SHALL end the packet and move the state to IDLE.
REQ-025 In PAYLOAD, if an accepted beat is beat number MAX_BEATS and carries tlast=0, it SHALL be forwarded with tlast_out=1, trunc_err SHALL pulse, and the state SHALL move to DROP.
REQ-026 In DROP, tready SHALL be forced high; all accepted beats SHALL be discarded (nothing enqueued), and the beat carrying tlast=1 SHALL return the state to IDLE.
REQ-027 A beat number MAX_BEATS that carries tlast=1 SHALL be a normal end of packet with no trunc_err.
REQ-028 pkt_done SHALL pulse, and pkt_len SHALL update, 1 cycle after the accepted beat that ends a forwarded packet (natural or truncated).
REQ-029 pkt_count SHALL increment at the same point as REQ-028 and SHALL wrap from 0xFFFF to 0.
REQ-030 No state SHALL reach DROP unless tvalid was high with tlast=0.

Reset
REQ-031 While aresetn is low: state SHALL be IDLE, the buffer empty, tready=0, tvalid_out=0, tlast_out=0, data_out=0, trunc_err=0, pkt_done=0, pkt_len=0 and pkt_count=0.
REQ-032 tready SHALL go high on the first rising aclk edge after aresetn deasserts.
REQ-033 Reset asserted mid-packet SHALL discard all buffered beats with no tlast_out emitted.

Structure
REQ-034 Package axis_pkt_pkg SHALL hold the state enum and a beat struct {data, last}.
REQ-035 The skid buffer SHALL be a separate sub-module, axis_skid_buf, parameterised by DATA_W.

Verification
REQ-036 Reset then a 4-beat packet 0x11..0x14 with tlast on 0x14, tready_in=1 -> 4 beats out, each 1 cycle later; tlast_out on 0x14; pkt_len=4; pkt_count=1.
REQ-037 With MAX_BEATS=16, send a 20-beat packet -> 16 beats out, tlast_out on beat 16, one trunc_err pulse, beats 17-20 dropped, pkt_len=16.
REQ-038 16-beat packet with tlast on beat 16 -> no trunc_err, pkt_len=16.
REQ-039 tready_in held low for 5 cycles during a streaming packet -> tready falls after 2 beats are buffered; no loss or duplication; data_out stable throughout the stall.
REQ-040 Back-to-back 1-beat packets for 10 cycles -> 10 pkt_done pulses, pkt_count=10, state stays IDLE.
REQ-041 aresetn pulsed low for 1 cycle at beat 3 of a 6-beat packet -> outputs match REQ-031; the next packet is forwarded intact.

Source files
------------

// File: rtl/axis_pkt_pkg.sv
// Shared types for the AXI-stream packet forwarder.
// FSM states, beat bundle and its builder.
package axis_pkt_pkg;

  localparam int BEAT_DATA_W = 64;

  typedef enum logic [1:0] {
    IDLE,
    PAYLOAD,
    DROP
  } state_e;

  typedef struct packed {
    logic [BEAT_DATA_W-1:0] data;
    logic                   last;
  } beat_t;

  function automatic beat_t mk_beat(
    input logic [BEAT_DATA_W-1:0] d,
    input logic                   l
  );
    beat_t b;
    b.data = d;
    b.last = l;
    return b;
  endfunction

endpackage

// File: rtl/axis_skid_buf.sv
// Two-entry skid buffer with a registered upstream ready.
// Head entry drives the outputs directly, so they hold during stalls.
module axis_skid_buf
  import axis_pkt_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic              in_last_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  output logic [DATA_W-1:0] out_data_o,
  output logic              out_last_o,
  output logic              out_valid_o,
  input  logic              out_ready_i
);

  beat_t      head_q, head_d;
  beat_t      tail_q, tail_d;
  beat_t      in_b;
  logic [1:0] cnt_q, cnt_d;
  logic       rdy_q;
  logic       push, pop;
  logic       unused_hi;

  assign in_b = mk_beat(BEAT_DATA_W'(in_data_i), in_last_i);

  assign push        = in_valid_i & rdy_q;
  assign out_valid_o = cnt_q != 2'd0;
  assign pop         = out_valid_o & out_ready_i;

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    unique case ({push, pop})
      2'b10: begin
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'd0) head_d = in_b;
        else               tail_d = in_b;
      end
      2'b01: begin
        cnt_d  = cnt_q - 2'd1;
        head_d = tail_q;
      end
      2'b11: begin
        head_d = (cnt_q == 2'd2) ? tail_q : in_b;
        tail_d = in_b;
      end
      default: ;
    endcase
  end

  // Ready is the registered image of "fewer than two held".
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
      rdy_q  <= 1'b0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
      rdy_q  <= cnt_d != 2'd2;
    end
  end

  assign in_ready_o = rdy_q;
  assign out_data_o = head_q.data[DATA_W-1:0];
  assign out_last_o = head_q.last;
  assign unused_hi  = ^head_q.data;

endmodule

// File: rtl/axis_pkt_fsm.sv
// Packet forwarder: truncates at MAX_BEATS and drops the remainder.
// Reports length and a running count of forwarded packets.
module axis_pkt_fsm
  import axis_pkt_pkg::*;
#(
  parameter  int DATA_W    = 8,
  parameter  int MAX_BEATS = 16,
  localparam int CNT_W     = $clog2(MAX_BEATS + 1)
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic [DATA_W-1:0] data_in,
  input  logic              tvalid,
  input  logic              tlast,
  output logic              tready,
  output logic [DATA_W-1:0] data_out,
  output logic              tvalid_out,
  output logic              tlast_out,
  input  logic              tready_in,
  output logic              trunc_err,
  output logic [CNT_W-1:0]  pkt_len,
  output logic              pkt_done,
  output logic [15:0]       pkt_count
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic [CNT_W-1:0] beat_n;
  logic [15:0]      count_q;
  logic             done_q, done_d;
  logic             trunc_q, trunc_d;
  logic             buf_ready;
  logic             acc;
  logic             enq, enq_last;

  assign tready = buf_ready | (state_q == DROP);
  assign acc    = tvalid & tready;
  assign beat_n = (state_q == IDLE) ? CNT_W'(1)
                                    : cnt_q + CNT_W'(1);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    len_d    = len_q;
    done_d   = 1'b0;
    trunc_d  = 1'b0;
    enq      = 1'b0;
    enq_last = tlast;
    unique case (state_q)
      IDLE, PAYLOAD: begin
        if (acc) begin
          enq   = 1'b1;
          cnt_d = beat_n;
          if (tlast) begin
            state_d = IDLE;
            done_d  = 1'b1;
            len_d   = beat_n;
          end else if (beat_n == CNT_W'(MAX_BEATS)) begin
            state_d  = DROP;
            enq_last = 1'b1;
            trunc_d  = 1'b1;
            done_d   = 1'b1;
            len_d    = beat_n;
          end else begin
            state_d = PAYLOAD;
          end
        end
      end
      // Tail of an over-long packet: swallow until its tlast.
      DROP: begin
        if (acc && tlast) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      len_q   <= '0;
      count_q <= '0;
      done_q  <= 1'b0;
      trunc_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      count_q <= count_q + {15'd0, done_d};
      done_q  <= done_d;
      trunc_q <= trunc_d;
    end
  end

  axis_skid_buf #(
    .DATA_W (DATA_W)
  ) u_skid (
    .clk_i       (aclk),
    .rst_ni      (aresetn),
    .in_data_i   (data_in),
    .in_last_i   (enq_last),
    .in_valid_i  (enq),
    .in_ready_o  (buf_ready),
    .out_data_o  (data_out),
    .out_last_o  (tlast_out),
    .out_valid_o (tvalid_out),
    .out_ready_i (tready_in)
  );

  assign trunc_err = trunc_q;
  assign pkt_done  = done_q;
  assign pkt_len   = len_q;
  assign pkt_count = count_q;

endmodule

// File: tb/tb_axis_pkt_fsm.sv
// Directed bench for axis_pkt_fsm.
// Hand-computed vectors; outputs sampled on the falling edge.
`timescale 1ns/1ps
module tb_axis_pkt_fsm;
  import axis_pkt_pkg::*;

  localparam int DW = 8;
  localparam int MB = 16;
  localparam int CW = $clog2(MB + 1);

  logic          aclk      = 1'b0;
  logic          aresetn   = 1'b0;
  logic [DW-1:0] data_in   = '0;
  logic          tvalid    = 1'b0;
  logic          tlast     = 1'b0;
  logic          tready;
  logic [DW-1:0] data_out;
  logic          tvalid_out;
  logic          tlast_out;
  logic          tready_in = 1'b1;
  logic          trunc_err;
  logic [CW-1:0] pkt_len;
  logic          pkt_done;
  logic [15:0]   pkt_count;

  int            n_cmp = 0;
  int            n_bad = 0;
  logic [8:0]    got_q[$];
  int            done_n = 0;
  int            trunc_n = 0;
  logic [CW-1:0] last_len = '0;
  logic          stall_q = 1'b0;
  logic [8:0]    held_q = '0;

  always #5 aclk = ~aclk;

  axis_pkt_fsm #(
    .DATA_W    (DW),
    .MAX_BEATS (MB)
  ) dut (
    .aclk       (aclk),
    .aresetn    (aresetn),
    .data_in    (data_in),
    .tvalid     (tvalid),
    .tlast      (tlast),
    .tready     (tready),
    .data_out   (data_out),
    .tvalid_out (tvalid_out),
    .tlast_out  (tlast_out),
    .tready_in  (tready_in),
    .trunc_err  (trunc_err),
    .pkt_len    (pkt_len),
    .pkt_done   (pkt_done),
    .pkt_count  (pkt_count)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  always @(negedge aclk) begin
    if (stall_q) begin
      chk("hold_v", tvalid_out, 1);
      chk("hold_d", {tlast_out, data_out}, held_q);
    end
    stall_q = tvalid_out & ~tready_in & aresetn;
    held_q  = {tlast_out, data_out};
    if (tvalid_out && tready_in)
      got_q.push_back({tlast_out, data_out});
    if (pkt_done) begin
      done_n++;
      last_len = pkt_len;
    end
    if (trunc_err) trunc_n++;
  end

  task automatic idle(input int n);
    repeat (n) @(posedge aclk);
    #1;
  endtask

  task automatic send(input logic [DW-1:0] d, input logic l);
    int guard = 0;
    data_in = d;
    tlast   = l;
    tvalid  = 1'b1;
    @(negedge aclk);
    while (!tready && guard < 50) begin
      guard++;
      @(negedge aclk);
    end
    if (!tready) chk("send_rdy", tready, 1);
    @(posedge aclk);
    #1;
    tvalid = 1'b0;
    tlast  = 1'b0;
  endtask

  task automatic chk_rst();
    chk("rst_rdy", tready, 0);
    chk("rst_vo", tvalid_out, 0);
    chk("rst_lo", tlast_out, 0);
    chk("rst_do", data_out, 0);
    chk("rst_te", trunc_err, 0);
    chk("rst_pd", pkt_done, 0);
    chk("rst_pl", pkt_len, 0);
    chk("rst_pc", pkt_count, 0);
    chk("rst_st", dut.state_q, IDLE);
  endtask

  task automatic do_reset();
    aresetn = 1'b0;
    tvalid  = 1'b0;
    repeat (2) @(posedge aclk);
    #1;
    chk_rst();
    @(negedge aclk);
    aresetn = 1'b1;
    #1;
    chk("rel_rdy0", tready, 0);
    idle(1);
    chk("rel_rdy1", tready, 1);
    got_q.delete();
    done_n  = 0;
    trunc_n = 0;
  endtask

  task automatic check_out(input string tag, input logic [DW-1:0] base,
                           input int n, input logic all_last);
    chk({tag, "_n"}, got_q.size(), n);
    for (int i = 0; i < n && i < got_q.size(); i++)
      chk({tag, "_beat"}, got_q[i],
          {(all_last || i == n - 1), base + 8'(i)});
    got_q.delete();
  endtask

  task automatic clr_cnt();
    done_n  = 0;
    trunc_n = 0;
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    do_reset();

    // 4-beat packet, one-cycle latency per beat
    for (int i = 0; i < 4; i++) begin
      send(8'h11 + 8'(i), i == 3);
      chk("t1_lat_v", tvalid_out, 1);
      chk("t1_lat_d", data_out, 8'h11 + 8'(i));
    end
    chk("t1_last", tlast_out, 1);
    idle(3);
    check_out("t1", 8'h11, 4, 1'b0);
    chk("t1_done", done_n, 1);
    chk("t1_len", last_len, 4);
    chk("t1_plen", pkt_len, 4);
    chk("t1_cnt", pkt_count, 1);
    chk("t1_trunc", trunc_n, 0);

    // 20 beats: truncated at 16, tail dropped
    clr_cnt();
    for (int i = 0; i < 20; i++)
      send(8'h20 + 8'(i), i == 19);
    idle(3);
    check_out("t2", 8'h20, 16, 1'b0);
    chk("t2_trunc", trunc_n, 1);
    chk("t2_done", done_n, 1);
    chk("t2_len", last_len, 16);
    chk("t2_cnt", pkt_count, 2);
    chk("t2_st", dut.state_q, IDLE);

    // exactly 16 beats: normal end
    clr_cnt();
    for (int i = 0; i < 16; i++)
      send(8'h40 + 8'(i), i == 15);
    idle(3);
    check_out("t3", 8'h40, 16, 1'b0);
    chk("t3_trunc", trunc_n, 0);
    chk("t3_done", done_n, 1);
    chk("t3_len", last_len, 16);
    chk("t3_cnt", pkt_count, 3);

    // downstream stall for 5 cycles mid-packet
    clr_cnt();
    fork
      begin
        for (int i = 0; i < 8; i++)
          send(8'h60 + 8'(i), i == 7);
      end
      begin
        idle(2);
        tready_in = 1'b0;
        idle(5);
        chk("t4_rdy_low", tready, 0);
        chk("t4_vo", tvalid_out, 1);
        tready_in = 1'b1;
      end
    join
    idle(4);
    check_out("t4", 8'h60, 8, 1'b0);
    chk("t4_done", done_n, 1);
    chk("t4_len", last_len, 8);
    chk("t4_cnt", pkt_count, 4);

    // 10 back-to-back single-beat packets
    do_reset();
    for (int i = 0; i < 10; i++) begin
      send(8'h80 + 8'(i), 1'b1);
      chk("t5_st", dut.state_q, IDLE);
    end
    idle(3);
    check_out("t5", 8'h80, 10, 1'b1);
    chk("t5_done", done_n, 10);
    chk("t5_cnt", pkt_count, 10);
    chk("t5_len", last_len, 1);
    chk("t5_trunc", trunc_n, 0);

    // reset pulse during beat 3 of a 6-beat packet
    send(8'hA0, 1'b0);
    send(8'hA1, 1'b0);
    data_in = 8'hA2;
    tvalid  = 1'b1;
    aresetn = 1'b0;
    #1;
    chk_rst();
    chk("t6_pre_n", got_q.size(), 1);
    if (got_q.size() > 0) chk("t6_pre_b", got_q[0], {1'b0, 8'hA0});
    got_q.delete();
    clr_cnt();
    @(posedge aclk);
    #1;
    chk("t6_in_rst_vo", tvalid_out, 0);
    aresetn = 1'b1;
    tvalid  = 1'b0;
    #1;
    chk("t6_rdy0", tready, 0);
    idle(1);
    chk("t6_rdy1", tready, 1);
    for (int i = 0; i < 3; i++)
      send(8'hB0 + 8'(i), i == 2);
    idle(3);
    check_out("t6", 8'hB0, 3, 1'b0);
    chk("t6_done", done_n, 1);
    chk("t6_cnt", pkt_count, 1);
    chk("t6_len", last_len, 3);
    chk("t6_trunc", trunc_n, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
